fsm_out_monitor: RTL and testbench

FSM_OUT_MONITOR -- requirements
Module: fsm_out_monitor

---
 rtl/fsm_out_monitor.sv | 194 +++++++++++++++++++
 tb/tb_fsm_out_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_out_monitor.sv
// Monitors the Moore outputs of a 5-state upstream sequencer: decodes its state, counts entries
// per state, tracks dwell time and flags illegal encodings or transitions.
module fsm_out_monitor (
    input  logic       clk,
    input  logic       rst,
    input  logic       o3,
    input  logic       u8,
    input  logic       U6,
    input  logic       U9,
    input  logic       clr,
    input  logic [2:0] sel,
    output logic [2:0] st_code,
    output logic       st_vld,
    output logic [7:0] visit_cnt,
    output logic [3:0] dwell,
    output logic       e0_lock,
    output logic       bad_state,
    output logic       bad_trans
);

    localparam logic [2:0] C1  = 3'd0;
    localparam logic [2:0] N7  = 3'd1;
    localparam logic [2:0] C2  = 3'd2;
    localparam logic [2:0] G1  = 3'd3;
    localparam logic [2:0] E0  = 3'd4;
    localparam logic [2:0] ILL = 3'd7;

    logic [3:0]      s1_bits_q;
    logic            s1_vld_q;
    logic [2:0]      dec_code;
    logic            dec_legal;
    logic            cnt_entry;
    logic [4:0][7:0] cnt_all;

    logic [2:0] st_code_q, st_code_d;
    logic       st_vld_q, st_vld_d;
    logic [2:0] prev_code_q, prev_code_d;
    logic       prev_vld_q, prev_vld_d;
    logic       first_chk_q, first_chk_d;
    logic [3:0] dwell_q, dwell_d;
    logic       e0_lock_q, e0_lock_d;
    logic       bad_state_q, bad_state_d;
    logic       bad_trans_q, bad_trans_d;

    function automatic logic legal_trans(input logic [2:0] prev, input logic [2:0] cur);
        case (prev)
            C1:      legal_trans = (cur == C1) || (cur == N7) || (cur == C2);
            N7:      legal_trans = (cur == C2) || (cur == G1);
            C2:      legal_trans = (cur == G1) || (cur == E0);
            G1:      legal_trans = (cur == N7);
            E0:      legal_trans = (cur == E0);
            default: legal_trans = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_bits_q <= 4'b0000;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_bits_q <= {o3, u8, U6, U9};
            s1_vld_q  <= 1'b1;
        end
    end

    always_comb begin
        dec_code = ILL;
        case (s1_bits_q)
            4'b1000: dec_code = C1;
            4'b0000: dec_code = N7;
            4'b1111: dec_code = C2;
            4'b0110: dec_code = G1;
            4'b0011: dec_code = E0;
            default: dec_code = ILL;
        endcase
    end

    assign dec_legal = (dec_code != ILL);
    // An entry is a legal code that differs from the previous one, or has no predecessor.
    assign cnt_entry = s1_vld_q && !clr && dec_legal &&
                       (!prev_vld_q || (prev_code_q != dec_code));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_code_q   <= ILL;
            st_vld_q    <= 1'b0;
            prev_code_q <= C1;
            prev_vld_q  <= 1'b0;
            first_chk_q <= 1'b1;
            dwell_q     <= 4'd0;
            e0_lock_q   <= 1'b0;
            bad_state_q <= 1'b0;
            bad_trans_q <= 1'b0;
        end else begin
            st_code_q   <= st_code_d;
            st_vld_q    <= st_vld_d;
            prev_code_q <= prev_code_d;
            prev_vld_q  <= prev_vld_d;
            first_chk_q <= first_chk_d;
            dwell_q     <= dwell_d;
            e0_lock_q   <= e0_lock_d;
            bad_state_q <= bad_state_d;
            bad_trans_q <= bad_trans_d;
        end
    end

    // Next-state logic
    always_comb begin
        st_code_d   = dec_code;
        st_vld_d    = s1_vld_q;
        prev_code_d = prev_code_q;
        prev_vld_d  = prev_vld_q;
        first_chk_d = first_chk_q;
        dwell_d     = dwell_q;
        e0_lock_d   = 1'b0;
        bad_state_d = bad_state_q;
        bad_trans_d = bad_trans_q;
        if (clr) begin
            prev_vld_d  = 1'b0;
            first_chk_d = 1'b0;
            dwell_d     = 4'd0;
            bad_state_d = 1'b0;
            bad_trans_d = 1'b0;
        end else if (s1_vld_q) begin
            first_chk_d = 1'b0;
            if (first_chk_q && (dec_code != C1)) begin
                bad_trans_d = 1'b1;
            end
            if (!dec_legal) begin
                bad_state_d = 1'b1;
                dwell_d     = 4'd0;
                prev_vld_d  = 1'b0;
            end else begin
                if (prev_vld_q && !legal_trans(prev_code_q, dec_code)) begin
                    bad_trans_d = 1'b1;
                end
                if (cnt_entry) begin
                    dwell_d = 4'd1;
                end else if (dwell_q != 4'hF) begin
                    dwell_d = dwell_q + 4'd1;
                end
                prev_code_d = dec_code;
                prev_vld_d  = 1'b1;
            end
            e0_lock_d = (dec_code == E0) && (dwell_d >= 4'd4);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cnt
            logic [7:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = 8'd0;
                end else if (cnt_entry && (dec_code == 3'(gi)) && (cnt_q != 8'hFF)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= 8'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    // Output logic
    always_comb begin
        st_code   = st_code_q;
        st_vld    = st_vld_q;
        dwell     = dwell_q;
        e0_lock   = e0_lock_q;
        bad_state = bad_state_q;
        bad_trans = bad_trans_q;
        case (sel)
            3'd0:    visit_cnt = cnt_all[0];
            3'd1:    visit_cnt = cnt_all[1];
            3'd2:    visit_cnt = cnt_all[2];
            3'd3:    visit_cnt = cnt_all[3];
            3'd4:    visit_cnt = cnt_all[4];
            default: visit_cnt = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_fsm_out_monitor.sv
// Directed bench for fsm_out_monitor: state patterns are fed one per clock and
// outputs are compared against hand-computed values one cycle behind the feed.
module tb_fsm_out_monitor;

    localparam logic [3:0] P_C1  = 4'b1000;
    localparam logic [3:0] P_N7  = 4'b0000;
    localparam logic [3:0] P_C2  = 4'b1111;
    localparam logic [3:0] P_G1  = 4'b0110;
    localparam logic [3:0] P_E0  = 4'b0011;
    localparam logic [3:0] P_BAD = 4'b0101;

    localparam logic [3:0] T2_PAT [10] = '{P_C1, P_N7, P_C2, P_G1, P_N7, P_C2, P_E0, P_E0, P_E0, P_E0};
    localparam int T2_CODE [10] = '{0, 1, 2, 3, 1, 2, 4, 4, 4, 4};
    localparam int T2_DWELL[10] = '{1, 1, 1, 1, 1, 1, 1, 2, 3, 4};
    localparam int T2_LOCK [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    logic       clk;
    logic       rst;
    logic       o3, u8, U6, U9;
    logic       clr;
    logic [2:0] sel;
    logic [2:0] st_code;
    logic       st_vld;
    logic [7:0] visit_cnt;
    logic [3:0] dwell;
    logic       e0_lock;
    logic       bad_state;
    logic       bad_trans;

    int n_checks;
    int n_errors;

    fsm_out_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .o3        (o3),
        .u8        (u8),
        .U6        (U6),
        .U9        (U9),
        .clr       (clr),
        .sel       (sel),
        .st_code   (st_code),
        .st_vld    (st_vld),
        .visit_cnt (visit_cnt),
        .dwell     (dwell),
        .e0_lock   (e0_lock),
        .bad_state (bad_state),
        .bad_trans (bad_trans)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pattern and clock it in; outputs then show the previously fed pattern.
    task automatic feed(input logic [3:0] bits);
        {o3, u8, U6, U9} = bits;
        tick();
    endtask

    task automatic chk_cnt(input string tag, input logic [2:0] s, input int exp);
        sel = s;
        #1;
        chk(tag, int'(visit_cnt), exp);
    endtask

    task automatic reset_to();
        clr = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clr = 1'b0;
        sel = 3'd0;
        {o3, u8, U6, U9} = P_C1;

        // Reset state and hold of C1 after release
        tick();
        chk("rst_code", int'(st_code), 7);
        chk("rst_vld", int'(st_vld), 0);
        chk("rst_dwell", int'(dwell), 0);
        chk("rst_cnt0", int'(visit_cnt), 0);
        chk("rst_flags", int'({e0_lock, bad_state, bad_trans}), 0);
        reset_to();
        feed(P_C1);
        chk("hold_vld_e1", int'(st_vld), 0);
        feed(P_C1);
        chk("hold_vld_e2", int'(st_vld), 1);
        chk("hold_code", int'(st_code), 0);
        chk("hold_dwell1", int'(dwell), 1);
        chk_cnt("hold_cnt0", 3'd0, 1);
        feed(P_C1);
        chk("hold_dwell2", int'(dwell), 2);
        feed(P_C1);
        chk("hold_dwell3", int'(dwell), 3);
        for (int k = 0; k < 14; k++) feed(P_C1);
        chk("hold_dwell_sat", int'(dwell), 15);
        chk_cnt("hold_cnt0_once", 3'd0, 1);
        chk("hold_flags", int'({e0_lock, bad_state, bad_trans}), 0);

        // Legal stream ending in E0 lock
        reset_to();
        feed(T2_PAT[0]);
        for (int i = 1; i <= 10; i++) begin
            feed(i < 10 ? T2_PAT[i] : P_E0);
            chk($sformatf("seq_code%0d", i - 1), int'(st_code), T2_CODE[i - 1]);
            chk($sformatf("seq_dwell%0d", i - 1), int'(dwell), T2_DWELL[i - 1]);
            chk($sformatf("seq_lock%0d", i - 1), int'(e0_lock), T2_LOCK[i - 1]);
        end
        chk("seq_bad", int'({bad_state, bad_trans}), 0);
        chk_cnt("seq_cnt_c1", 3'd0, 1);
        chk_cnt("seq_cnt_n7", 3'd1, 2);
        chk_cnt("seq_cnt_c2", 3'd2, 2);
        chk_cnt("seq_cnt_g1", 3'd3, 1);
        chk_cnt("seq_cnt_e0", 3'd4, 1);

        // Illegal encoding, sticky bad_state, then clr
        reset_to();
        feed(P_C1);
        feed(P_BAD);
        feed(P_C1);
        chk("ill_code", int'(st_code), 7);
        chk("ill_dwell", int'(dwell), 0);
        chk("ill_bad_state", int'(bad_state), 1);
        feed(P_C1);
        chk("ill_after_code", int'(st_code), 0);
        chk("ill_after_dwell", int'(dwell), 1);
        chk("ill_sticky", int'(bad_state), 1);
        chk("ill_no_trans", int'(bad_trans), 0);
        chk_cnt("ill_cnt_c1", 3'd0, 2);
        clr = 1'b1;
        feed(P_C1);
        clr = 1'b0;
        chk("clr_bad_state", int'(bad_state), 0);
        chk("clr_dwell", int'(dwell), 0);
        chk("clr_code", int'(st_code), 0);
        chk("clr_vld", int'(st_vld), 1);
        chk_cnt("clr_cnt_c1", 3'd0, 0);
        feed(P_C1);
        chk_cnt("clr_first_cnt", 3'd0, 1);
        chk("clr_first_dwell", int'(dwell), 1);
        chk("clr_first_trans", int'(bad_trans), 0);

        // First sample G1 after reset
        reset_to();
        feed(P_G1);
        feed(P_G1);
        chk("first_g1_code", int'(st_code), 3);
        chk("first_g1_trans", int'(bad_trans), 1);
        chk_cnt("first_g1_cnt", 3'd3, 1);

        // C2 -> C1 illegal transition, counts still update
        reset_to();
        feed(P_C1);
        feed(P_C2);
        feed(P_C1);
        chk("c1c2_trans", int'(bad_trans), 0);
        feed(P_C1);
        chk("c2c1_trans", int'(bad_trans), 1);
        chk("c2c1_dwell", int'(dwell), 1);
        chk_cnt("c2c1_cnt_c1", 3'd0, 2);
        chk_cnt("c2c1_cnt_c2", 3'd2, 1);

        // Counter saturation with alternating C1/N7
        reset_to();
        for (int i = 0; i < 510; i++) feed((i % 2 == 0) ? P_C1 : P_N7);
        chk_cnt("sat_pre_c1", 3'd0, 255);
        chk_cnt("sat_pre_n7", 3'd1, 254);
        for (int i = 510; i < 600; i++) feed((i % 2 == 0) ? P_C1 : P_N7);
        tick();
        tick();
        chk_cnt("sat_c1", 3'd0, 255);
        chk_cnt("sat_n7", 3'd1, 255);
        chk_cnt("sat_sel5", 3'd5, 0);
        chk_cnt("sat_sel7", 3'd7, 0);

        // E0 lock then asynchronous reset
        reset_to();
        feed(P_C1);
        feed(P_C2);
        for (int i = 0; i < 5; i++) feed(P_E0);
        chk("lock_on", int'(e0_lock), 1);
        rst = 1'b1;
        #1;
        chk("arst_code", int'(st_code), 7);
        chk("arst_vld", int'(st_vld), 0);
        chk("arst_dwell", int'(dwell), 0);
        chk("arst_lock", int'(e0_lock), 0);
        chk_cnt("arst_cnt_e0", 3'd4, 0);
        tick();
        rst = 1'b0;
        feed(P_C1);
        feed(P_C1);
        chk("post_vld", int'(st_vld), 1);
        chk("post_code", int'(st_code), 0);
        chk("post_trans", int'(bad_trans), 0);
        chk_cnt("post_cnt_c1", 3'd0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
